mc_exec_sequencer: RTL and testbench
====================================

# mc_exec_sequencer

Multi-cycle execute sequencer for the processor's long-latency units: the iterative multiplier (MUL/UMULL/SMULL) and the FPU. It accepts one decoded multi-cycle instruction, stalls the pipeline, and issues a start pulse to the selected unit. It then waits for that unit's done with a timeout and drives the single register-file write port for one writeback (32-bit result) or two (64-bit long multiply, low then high). It sits between the decoder outputs (unit select, long-multiply flag, flag-write enables) and the register file/flag logic.

## Interface
- TIMEOUT, 64, maximum WAIT cycles before abandoning the operation (≥2)
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W ≥ TIMEOUT

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  decoded multi-cycle instruction valid; sampled only in IDLE
- flush  in  1  synchronous abort; returns to IDLE, no writes
- unit_sel  in  1  0 = multiplier, 1 = FPU
- mul_long  in  1  64-bit result, two writebacks (ignored when unit_sel=1)
- rd_lo  in  4  destination of the first/only write
- rd_hi  in  4  destination of the high word
- flag_w  in  2  flag-write enables for this instruction
- mul_done  in  1  multiplier result valid (single-cycle pulse or level)
- fpu_done  in  1  FPU result valid
- mul_start  out  1  one-cycle issue pulse to the multiplier
- fpu_start  out  1  one-cycle issue pulse to the FPU
- we  out  1  register-file write enable
- wa  out  4  register-file write address
- wd_sel  out  2  write-data mux: 00 mul low, 01 mul high, 10 FPU result
- flag_we  out  2  flag register write enables
- stall  out  1  freeze fetch/decode
- busy  out  1  state ≠ IDLE
- error  out  1  sticky timeout indication

## Operation
- States: IDLE, ISSUE, WAIT, WB_LO, WB_HI.
- IDLE:
  - start=1 and flush=0: latch unit_sel, mul_long & ~unit_sel, rd_lo, rd_hi, flag_w; clear error; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: assert mul_start or fpu_start per latched unit_sel for exactly one cycle; clear counter; go to WAIT. Done inputs are ignored in ISSUE.
- WAIT: monitor only the selected unit's done.
  - done=1: go to WB_LO.
  - done=0 and cnt = TIMEOUT-1: set error, go to IDLE; no write.
  - Otherwise increment cnt.
  - done and the timeout condition in the same cycle: done wins.
- WB_LO: we=1, wa=rd_lo, wd_sel=00 (mul) or 10 (FPU), flag_we=latched flag_w.
  - Latched mul_long: go to WB_HI.
  - Otherwise go to IDLE.
- WB_HI: we=1, wa=rd_hi, wd_sel=01, flag_we=00; go to IDLE.
- rd_lo = rd_hi on a long multiply: both writes still occur; the high word lands last and wins.
- flush=1 in any state: next state IDLE. In that cycle we, flag_we, mul_start and fpu_start are forced to 0. error is unchanged. flush overrides start in IDLE.
- The non-selected unit's start output is never asserted.
- stall = busy | (start & ~flush & state==IDLE), combinational, so the pipeline freezes in the accept cycle.
- In every state not listed above: we=0, wa=0, wd_sel=00, flag_we=00.

## Timing
- Reset: state=IDLE, cnt=0, error=0, all latched fields 0. All outputs are 0 while reset is asserted and after release.
- start sampled in cycle 0 → ISSUE in cycle 1 (unit start pulse) → WAIT from cycle 2.
- done first seen in WAIT at cycle c → WB_LO at c+1, WB_HI at c+2 (long multiply only).
- Return to IDLE: c+2 for a single write, c+3 for a long multiply.
- Minimum latency with done in cycle 2: 32-bit op occupies 4 cycles (0–3); long multiply 5 cycles.
- WAIT lasts at most TIMEOUT cycles. Timeout exit: error rises on the edge into IDLE, i.e. cycle 2+TIMEOUT.
- The next start is accepted in the first IDLE cycle; there are no dead cycles between instructions.
- Asynchronous reset mid-operation: immediate return to IDLE; any pending write is lost.

## Test plan
- MUL, unit_sel=0, mul_long=0, rd_lo=4, flag_w=2'b10, mul_done 3 cycles after mul_start → one write (we=1, wa=4, wd_sel=00, flag_we=10); stall high for cycles 0–5, low at cycle 6.
- UMULL, mul_long=1, rd_lo=2, rd_hi=3, mul_done at cycle 2 → WB_LO cycle 3 (wa=2, wd_sel=00), WB_HI cycle 4 (wa=3, wd_sel=01, flag_we=00); IDLE at cycle 5.
- FPU op, unit_sel=1, mul_long=1, rd_lo=7, fpu_done at cycle 4 → single write wa=7, wd_sel=10; mul_start never asserted; mul_done pulses during WAIT are ignored.
- TIMEOUT=8, done never asserted → no we; error=1 from cycle 10. A subsequent start clears error in its accept cycle.
- flush asserted during WAIT at cycle 3 with mul_done also 1 → no write; IDLE at cycle 4. flush with start in IDLE → stays IDLE, stall=0.
- Back-to-back: a second start in the first IDLE cycle after a long multiply → accepted with no gap; reset pulsed during WB_LO → we drops immediately, state IDLE.

Source files
------------

// File: rtl/mc_exec_sequencer_if.sv
// Decoder/register-file side bundle of the multi-cycle execute sequencer.
// The master is the pipeline front; the sequencer takes the slave modport.
interface mc_exec_sequencer_if;
  logic       start;
  logic       flush;
  logic       unit_sel;
  logic       mul_long;
  logic [3:0] rd_lo;
  logic [3:0] rd_hi;
  logic [1:0] flag_w;
  logic       mul_done;
  logic       fpu_done;
  logic       mul_start;
  logic       fpu_start;
  logic       we;
  logic [3:0] wa;
  logic [1:0] wd_sel;
  logic [1:0] flag_we;
  logic       stall;
  logic       busy;
  logic       error;

  modport master (
    output start, flush, unit_sel, mul_long, rd_lo, rd_hi, flag_w, mul_done, fpu_done,
    input  mul_start, fpu_start, we, wa, wd_sel, flag_we, stall, busy, error
  );

  modport slave (
    input  start, flush, unit_sel, mul_long, rd_lo, rd_hi, flag_w, mul_done, fpu_done,
    output mul_start, fpu_start, we, wa, wd_sel, flag_we, stall, busy, error
  );
endinterface

// File: rtl/mc_exec_sequencer.sv
// Multi-cycle execute sequencer: issues one long-latency op to the multiplier
// or FPU, waits for done with a timeout, then drives one or two writebacks.
module mc_exec_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input logic               clk,
  input logic               reset,
  mc_exec_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB_LO = 3'd3,
    S_WB_HI = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               error_q, error_d;
  logic               unit_q, unit_d;
  logic               long_q, long_d;
  logic [3:0]         rd_lo_q, rd_lo_d;
  logic [3:0]         rd_hi_q, rd_hi_d;
  logic [1:0]         flag_w_q, flag_w_d;

  logic               mul_start_s;
  logic               fpu_start_s;
  logic               we_s;
  logic [3:0]         wa_s;
  logic [1:0]         wd_sel_s;
  logic [1:0]         flag_we_s;
  logic               done_s;

  // State and latched-instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      unit_q   <= 1'b0;
      long_q   <= 1'b0;
      rd_lo_q  <= 4'd0;
      rd_hi_q  <= 4'd0;
      flag_w_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      unit_q   <= unit_d;
      long_q   <= long_d;
      rd_lo_q  <= rd_lo_d;
      rd_hi_q  <= rd_hi_d;
      flag_w_q <= flag_w_d;
    end
  end

  // Next-state and output decode; flush overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    unit_d      = unit_q;
    long_d      = long_q;
    rd_lo_d     = rd_lo_q;
    rd_hi_d     = rd_hi_q;
    flag_w_d    = flag_w_q;
    mul_start_s = 1'b0;
    fpu_start_s = 1'b0;
    we_s        = 1'b0;
    wa_s        = 4'd0;
    wd_sel_s    = 2'b00;
    flag_we_s   = 2'b00;
    done_s      = unit_q ? bus.fpu_done : bus.mul_done;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          unit_d   = bus.unit_sel;
          long_d   = bus.mul_long & ~bus.unit_sel;
          rd_lo_d  = bus.rd_lo;
          rd_hi_d  = bus.rd_hi;
          flag_w_d = bus.flag_w;
          error_d  = 1'b0;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        mul_start_s = ~unit_q;
        fpu_start_s = unit_q;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last permitted cycle still completes.
        if (done_s) begin
          state_d = S_WB_LO;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_WB_LO: begin
        we_s      = 1'b1;
        wa_s      = rd_lo_q;
        wd_sel_s  = unit_q ? 2'b10 : 2'b00;
        flag_we_s = flag_w_q;
        if (long_q) begin
          state_d = S_WB_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB_HI: begin
        we_s     = 1'b1;
        wa_s     = rd_hi_q;
        wd_sel_s = 2'b01;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flush) begin
      state_d     = S_IDLE;
      error_d     = error_q;
      we_s        = 1'b0;
      flag_we_s   = 2'b00;
      mul_start_s = 1'b0;
      fpu_start_s = 1'b0;
    end else begin
      state_d     = state_d;
    end
  end

  assign bus.mul_start = mul_start_s;
  assign bus.fpu_start = fpu_start_s;
  assign bus.we        = we_s;
  assign bus.wa        = wa_s;
  assign bus.wd_sel    = wd_sel_s;
  assign bus.flag_we   = flag_we_s;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.error     = error_q;
  // Accept-cycle stall is combinational; held low while reset is asserted.
  assign bus.stall     = (state_q != S_IDLE) |
                         (bus.start & ~bus.flush & (state_q == S_IDLE) & ~reset);

endmodule

// File: tb/tb_mc_exec_sequencer.sv
// Self-checking bench for mc_exec_sequencer: directed scenarios plus randomized
// transactions checked against a per-transaction timeline model.
module tb_mc_exec_sequencer;

  localparam int TO = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mc_exec_sequencer_if bus ();

  mc_exec_sequencer #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, fl, us, ml;
    logic [3:0]  lo, hi;
    logic [1:0]  fw;
    logic        md, fd;
    logic [13:0] ex;
  } cyc_t;

  function automatic logic [13:0] mk(input logic ms, fs, we, input logic [3:0] wa,
                                     input logic [1:0] wd, fwe, input logic stl, bsy, err);
    return {ms, fs, we, wa, wd, fwe, stl, bsy, err};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.mul_start, bus.fpu_start, bus.we, bus.wa, bus.wd_sel, bus.flag_we,
            bus.stall, bus.busy, bus.error};
  endfunction

  task automatic drive(input logic st, fl, us, ml, input logic [3:0] lo, hi,
                       input logic [1:0] fw, input logic md, fd);
    bus.start = st; bus.flush = fl; bus.unit_sel = us; bus.mul_long = ml;
    bus.rd_lo = lo; bus.rd_hi = hi; bus.flag_w = fw; bus.mul_done = md; bus.fpu_done = fd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 2'b11, 1'b1, 1'b1);
    tick(); tick();
    #1;
    checks++;
    if (obs() !== 14'd0) begin
      errors++; $display("FAIL reset_held: got %h expected %h", obs(), 14'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 14'd0) begin
      errors++; $display("FAIL reset_release: got %h expected %h", obs(), 14'd0);
    end
    tick();
  endtask

  task automatic test_mul32();
    logic [13:0] ex [7];
    ex[0] = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    ex[1] = mk(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    ex[2] = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    ex[3] = ex[2];
    ex[4] = ex[2];
    ex[5] = mk(1'b0, 1'b0, 1'b1, 4'd4, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
    ex[6] = 14'd0;
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd9, 2'b10, c == 4, 1'b0);
      #1;
      checks++;
      if (obs() !== ex[c]) begin
        errors++; $display("FAIL mul32 cycle %0d: got %h expected %h", c, obs(), ex[c]);
      end
      tick();
    end
  endtask

  task automatic test_umull();
    logic [13:0] ex [6];
    ex[0] = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    ex[1] = mk(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    ex[2] = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    ex[3] = mk(1'b0, 1'b0, 1'b1, 4'd2, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
    ex[4] = mk(1'b0, 1'b0, 1'b1, 4'd3, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    ex[5] = 14'd0;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 2'b11, c == 2, 1'b0);
      #1;
      checks++;
      if (obs() !== ex[c]) begin
        errors++; $display("FAIL umull cycle %0d: got %h expected %h", c, obs(), ex[c]);
      end
      tick();
    end
  endtask

  task automatic test_fpu();
    logic [13:0] ex [7];
    ex[0] = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    ex[1] = mk(1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    ex[2] = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    ex[3] = ex[2];
    ex[4] = ex[2];
    ex[5] = mk(1'b0, 1'b0, 1'b1, 4'd7, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
    ex[6] = 14'd0;
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd9, 2'b01, (c == 2) || (c == 3), c == 4);
      #1;
      checks++;
      if (obs() !== ex[c]) begin
        errors++; $display("FAIL fpu cycle %0d: got %h expected %h", c, obs(), ex[c]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    for (int c = 0; c < 12; c++) begin
      drive(c == 0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 2'b11, 1'b0, 1'b1);
      if (c == 0)       e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      else if (c == 1)  e = mk(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      else if (c < 10)  e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      else              e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL timeout cycle %0d: got %h expected %h", c, obs(), e);
      end
      tick();
    end
    // New op after timeout: error still visible in accept cycle, gone after.
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 2'b00, c == 2, 1'b0);
      if (c == 0)      e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
      else if (c == 1) e = mk(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      else if (c == 2) e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      else if (c == 3) e = mk(1'b0, 1'b0, 1'b1, 4'd6, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      else             e = 14'd0;
      #1;
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL error_clear cycle %0d: got %h expected %h", c, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [13:0] e;
    logic [13:0] wt;
    wt = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    // Flush in WAIT with done present, then flush racing a start in IDLE.
    for (int c = 0; c < 7; c++) begin
      drive((c == 0) || (c == 5), (c == 3) || (c == 5), 1'b0, 1'b0, 4'd5, 4'd0, 2'b01,
            c == 3, 1'b0);
      if (c == 0)      e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      else if (c == 1) e = mk(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      else if (c < 4)  e = wt;
      else             e = 14'd0;
      #1;
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL flush_wait cycle %0d: got %h expected %h", c, obs(), e);
      end
      tick();
    end
    // Flush during ISSUE suppresses the start pulse.
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, c == 1, 1'b1, 1'b0, 4'd5, 4'd0, 2'b01, 1'b0, 1'b0);
      if (c == 0)      e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      else if (c == 1) e = wt;
      else             e = 14'd0;
      #1;
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL flush_issue cycle %0d: got %h expected %h", c, obs(), e);
      end
      tick();
    end
    // Flush during WB_LO suppresses the write and flag update.
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, c == 3, 1'b0, 1'b1, 4'd5, 4'd6, 2'b11, c == 2, 1'b0);
      #1;
      if (c == 3) begin
        checks++;
        if ({bus.we, bus.flag_we, bus.busy} !== 4'b0001) begin
          errors++;
          $display("FAIL flush_wb we/flag_we/busy: got %b expected 0001",
                   {bus.we, bus.flag_we, bus.busy});
        end
      end else if (c == 4) begin
        checks++;
        if (obs() !== 14'd0) begin
          errors++; $display("FAIL flush_wb idle: got %h expected %h", obs(), 14'd0);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    logic [13:0] wt;
    wt = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 9; c++) begin
      if (c < 5) drive(c == 0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 2'b10, c == 2, 1'b0);
      else       drive(c == 5, 1'b0, 1'b1, 1'b0, 4'd6, 4'd8, 2'b11, 1'b0, c == 7);
      case (c)
        0:       e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        1:       e = mk(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        3:       e = mk(1'b0, 1'b0, 1'b1, 4'd1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        4:       e = mk(1'b0, 1'b0, 1'b1, 4'd2, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        5:       e = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        6:       e = mk(1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        8:       e = mk(1'b0, 1'b0, 1'b1, 4'd6, 2'b10, 2'b11, 1'b1, 1'b1, 1'b0);
        default: e = wt;
      endcase
      #1;
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs(), e);
      end
      if (c < 8) tick();
    end
    // Asynchronous reset in WB_LO drops the write immediately.
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 14'd0) begin
      errors++; $display("FAIL reset_in_wb: got %h expected %h", obs(), 14'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (obs() !== 14'd0) begin
      errors++; $display("FAIL after_reset_idle: got %h expected %h", obs(), 14'd0);
    end
    tick();
  endtask

  task automatic test_random();
    cyc_t q[$];
    cyc_t e;
    logic merr;
    merr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      int gap;
      logic us, ml, lng, tmo, sel;
      logic [3:0] lo, hi;
      logic [1:0] fw;
      int d, wait_end, total;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        e.st = 1'b0; e.fl = 1'b0; e.us = 1'(($urandom)); e.ml = 1'(($urandom));
        e.lo = 4'($urandom); e.hi = 4'($urandom); e.fw = 2'($urandom);
        e.md = 1'($urandom); e.fd = 1'($urandom);
        e.ex = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, merr);
        q.push_back(e);
      end
      us  = 1'($urandom);
      ml  = 1'($urandom);
      lo  = 4'($urandom);
      hi  = ($urandom_range(0, 3) == 0) ? lo : 4'($urandom);
      fw  = 2'($urandom);
      d   = $urandom_range(0, TO);
      tmo = (d == TO);
      lng = ml & ~us;
      wait_end = tmo ? (1 + TO) : (2 + d);
      total    = tmo ? (2 + TO) : (wait_end + (lng ? 3 : 2));
      for (int c = 0; c < total; c++) begin
        e.st = (c == 0); e.fl = 1'b0; e.us = us; e.ml = ml;
        e.lo = lo; e.hi = hi; e.fw = fw;
        e.md = 1'($urandom); e.fd = 1'($urandom);
        sel = 1'($urandom);
        if (c >= 2 && c <= wait_end) sel = (!tmo && c == wait_end);
        if (us) e.fd = sel; else e.md = sel;
        if (c == 0)
          e.ex = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, merr);
        else if (c == 1)
          e.ex = mk(~us, us, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        else if (c <= wait_end)
          e.ex = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        else if (c == wait_end + 1)
          e.ex = mk(1'b0, 1'b0, 1'b1, lo, us ? 2'b10 : 2'b00, fw, 1'b1, 1'b1, 1'b0);
        else
          e.ex = mk(1'b0, 1'b0, 1'b1, hi, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        q.push_back(e);
      end
      merr = tmo;
    end
    e.st = 1'b0; e.fl = 1'b0; e.us = 1'b0; e.ml = 1'b0; e.lo = 4'd0; e.hi = 4'd0;
    e.fw = 2'b00; e.md = 1'b0; e.fd = 1'b0;
    e.ex = mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, merr);
    q.push_back(e);
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i].st, q[i].fl, q[i].us, q[i].ml, q[i].lo, q[i].hi, q[i].fw, q[i].md, q[i].fd);
      #1;
      checks++;
      if (obs() !== q[i].ex) begin
        errors++; $display("FAIL random step %0d: got %h expected %h", i, obs(), q[i].ex);
      end
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    test_reset();
    test_mul32();
    test_umull();
    test_fpu();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
